pipemem_arb: RTL and testbench
==============================

Name: pipemem_arb

Overview:
- Arbiter and sequencer for one single-port unified instruction/data memory, shared between the IF stage and the MEM stage.
- The MEM stage is driven by the EX/MEM pipeline register outputs: wmem, m2reg, alu result as address, and b as store data.
- Accesses are serialized; MEM has priority because it holds the older instruction.
- A global stall freezes PC, IF/ID, ID/EX and EX/MEM until every pending access completes.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- if_req  in  1  fetch request, high every cycle the IF stage is active
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  fetched instruction, registered
- m_wmem  in  1  store request (EX/MEM wmem)
- m_m2reg  in  1  load request (EX/MEM m2reg)
- m_addr  in  AW  data address (EX/MEM alu)
- m_wdata  in  DW  store data (EX/MEM b)
- m_rdata  out  DW  load data, registered
- stall  out  1  freeze pipeline registers and PC, combinational
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data, valid exactly MEM_LAT cycles after mem_en
- stall_cnt  out  32  stall-cycle count (only with PIPEMEM_ARB_PERF_EN, else tied to 0)

Behaviour:
- Reset values: every registered output is 0, state is IDLE, m_done=0, if_done=0, and the latency counter is 0.
- Request definitions:
  - m_req = m_wmem | m_m2reg.
  - If m_wmem and m_m2reg are both high, the access is treated as a store.
- Stall: stall = (m_req & ~m_done) | (if_req & ~if_done).
  - Requesters hold their inputs stable while stall=1; the frozen pipeline guarantees this.
- On any rising edge with stall=0, m_done and if_done clear; the next instruction set then presents new requests.
- FSM states: IDLE, RD_M, RD_IF.
- IDLE:
  - If m_req & ~m_done: issue the MEM access (mem_en=1, mem_we=m_wmem, mem_addr=m_addr, mem_wdata=m_wdata).
    - Store: set m_done at issue (posted write) and stay in IDLE.
    - Load: load counter with MEM_LAT and go to RD_M.
  - Else if if_req & ~if_done: issue the fetch (mem_en=1, mem_we=0, mem_addr=if_addr), load counter with MEM_LAT, go to RD_IF.
  - Otherwise mem_en=0.
- RD_M / RD_IF:
  - mem_en=0; decrement the counter each cycle.
  - When the counter reaches 0: capture mem_rdata into m_rdata or if_rdata, set the matching done flag, and return to IDLE.
  - IDLE re-evaluates on the next edge, so at most one idle gap occurs between back-to-back accesses.
- Latency figures:
  - Uncontended load: stall for MEM_LAT+1 cycles.
  - Uncontended fetch: MEM_LAT+1 cycles.
  - Store: 1 cycle.
  - Load plus fetch in the same instruction slot: 2*(MEM_LAT+1) cycles; MEM is served first.
- Only one access is in flight at a time; a new access is never issued while in RD_*.
- A request that drops while its access is in flight (not legal under the stall contract): the access still completes, and its data and done flag are still written.
- Reset mid-access: immediate return to IDLE and all flags cleared; any in-flight memory response is ignored.
- m_rdata and if_rdata hold their last captured value until overwritten.

Optional Feature:
- Macro: PIPEMEM_ARB_PERF_EN.
- Defined:
  - stall_cnt increments by 1 on every clock with stall=1 and saturates at 32'hFFFF_FFFF.
  - Reset clears it to 0.
- Undefined: no counter logic; stall_cnt is driven to constant 0.

Decomposition:
- Shared package pipe_pkg:
  - FSM state encoding (IDLE=2'd0, RD_M=2'd1, RD_IF=2'd2).
  - Default MEM_LAT constant.
  - AW/DW defaults.
- One natural sub-module, pipemem_lat_cnt:
  - Loadable down-counter with load, value, and zero flag.
  - Width of 4 bits, covering MEM_LAT up to 15.

Test Plan:
- Reset release, if_req=1, if_addr=0x0, MEM_LAT=2, mem_rdata=0x2002_0001 two cycles after mem_en:
  - stall high 3 cycles, then if_rdata=0x2002_0001 and stall=0.
- Load plus fetch together, m_m2reg=1, m_addr=0x40, mem returns 0xDEAD_BEEF, then fetch at 0x8 returns 0x1234_5678:
  - mem_addr sequence is 0x40 then 0x8.
  - stall high 6 cycles; m_rdata=0xDEAD_BEEF, if_rdata=0x1234_5678.
- Store plus fetch, m_wmem=1, m_addr=0x10, m_wdata=0xA5A5_A5A5:
  - one cycle with mem_we=1, mem_wdata=0xA5A5_A5A5.
  - then a fetch; total stall 4 cycles.
- m_wmem=1 and m_m2reg=1 together: exactly one access with mem_we=1, treated as a store.
- rst=0 asserted in the middle of RD_M:
  - all outputs go to 0 asynchronously.
  - after release a fresh fetch completes normally; the stale mem_rdata is not captured.
- With PIPEMEM_ARB_PERF_EN, run the load-plus-fetch scenario: stall_cnt=6. Without the macro: stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and defaults for the unified-memory arbiter
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_M  = 2'd1,
        RD_IF = 2'd2
    } arb_state_t;

    localparam int MEM_LAT_DEF = 2;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/pipemem_lat_cnt.sv
// rtl/pipemem_lat_cnt.sv - loadable 4-bit latency down-counter with zero flag
module pipemem_lat_cnt
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/pipemem_arb.sv
// rtl/pipemem_arb.sv - IF/MEM arbiter for a single-port memory; PIPEMEM_ARB_PERF_EN adds a stall counter
module pipemem_arb
    import pipe_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    input  logic          m_wmem,
    input  logic          m_m2reg,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    output logic [DW-1:0] m_rdata,
    output logic          stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT);

    arb_state_t       state, state_nxt;
    logic             m_done, if_done;
    logic             m_req, m_pend, if_pend;
    logic             issue_m, issue_if, in_rd, rd_last;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign m_req   = m_wmem | m_m2reg;
    assign m_pend  = m_req & ~m_done;
    assign if_pend = if_req & ~if_done;
    assign stall   = m_pend | if_pend;

    // MEM wins: it belongs to the older instruction in the pipe
    assign issue_m  = (state == IDLE) && m_pend;
    assign issue_if = (state == IDLE) && !m_pend && if_pend;
    assign in_rd    = (state == RD_M) || (state == RD_IF);
    // The edge on which the counter steps from 1 to 0 is the data-valid edge
    assign rd_last  = in_rd && (cnt_val == CNT_W'(1));

    assign cnt_load = (issue_m && !m_wmem) || issue_if;
    assign cnt_dec  = in_rd && !cnt_zero;

    pipemem_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_LD),
        .dec      (cnt_dec),
        .value    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_m && !m_wmem) begin
                    state_nxt = RD_M;
                end else if (issue_if) begin
                    state_nxt = RD_IF;
                end
            end
            RD_M, RD_IF: begin
                if (rd_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= issue_m || issue_if;
            mem_we <= issue_m && m_wmem;
            if (issue_m) begin
                mem_addr  <= m_addr;
                mem_wdata <= m_wdata;
            end else if (issue_if) begin
                mem_addr  <= if_addr;
            end
        end
    end

    // A completing access still records its data/done even if its request vanished
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_done   <= 1'b0;
            if_done  <= 1'b0;
            m_rdata  <= '0;
            if_rdata <= '0;
        end else begin
            if ((issue_m && m_wmem) || (state == RD_M && rd_last)) begin
                m_done <= 1'b1;
            end else if (!stall) begin
                m_done <= 1'b0;
            end
            if (state == RD_IF && rd_last) begin
                if_done <= 1'b1;
            end else if (!stall) begin
                if_done <= 1'b0;
            end
            if (state == RD_M && rd_last) begin
                m_rdata <= mem_rdata;
            end
            if (state == RD_IF && rd_last) begin
                if_rdata <= mem_rdata;
            end
        end
    end

`ifdef PIPEMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipemem_arb.sv
// tb/tb_pipemem_arb.sv - self-checking bench for pipemem_arb with a latency-accurate memory
`timescale 1ns/1ps
module tb_pipemem_arb;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        m_wmem = 1'b0;
    logic        m_m2reg = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata;
    logic        stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    pipemem_arb #(.MEM_LAT(L), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .m_wmem    (m_wmem),
        .m_m2reg   (m_m2reg),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .stall     (stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_cnt (stall_cnt)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rd_due = -1;
    logic [31:0] rd_data = '0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_wdata[$];
    int          exp_total = 0;
    logic [31:0] exp_m = '0;
    logic [31:0] exp_if = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: writes land at once, reads return data for the capture edge L after issue
    always @(negedge clk) begin
        if (rst && mem_en) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wdata.push_back(mem_wdata);
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
            end else begin
                rd_due  = cyc + L - 1;
                rd_data = mem_rd(mem_addr);
            end
        end
        if (cyc == rd_due) mem_rdata = rd_data;
        else               mem_rdata = $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_req = 1'b0; m_wmem = 1'b0; m_m2reg = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_total = 0; exp_m = '0; exp_if = '0;
    endtask

    // One instruction slot: called at a negedge, returns at the negedge after the pipeline advanced
    task automatic run_slot(input logic wm, input logic mr, input logic [31:0] ma,
                            input logic [31:0] wd, input logic ir, input logic [31:0] ia,
                            input string tag);
        logic        st, ld;
        int          exp_stall, n;
        logic [31:0] ea[$];
        logic        ewe[$];
        logic [31:0] ewd[$];
        st = wm;
        ld = mr & ~wm;
        exp_stall = (st ? 1 : 0) + (ld ? L + 1 : 0) + (ir ? L + 1 : 0);
        if (st) begin ea.push_back(ma); ewe.push_back(1'b1); ewd.push_back(wd); end
        if (ld) begin ea.push_back(ma); ewe.push_back(1'b0); ewd.push_back('0); exp_m = mem_rd(ma); end
        if (ir) begin
            ea.push_back(ia); ewe.push_back(1'b0); ewd.push_back('0);
            exp_if = (st && ia == ma) ? wd : mem_rd(ia);
        end
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        m_wmem = wm; m_m2reg = mr; m_addr = ma; m_wdata = wd; if_req = ir; if_addr = ia;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
            #1;
        end
        exp_total += exp_stall;
        check({tag, "_stall"}, 32'(n), 32'(exp_stall));
        check({tag, "_m_rdata"}, m_rdata, exp_m);
        check({tag, "_if_rdata"}, if_rdata, exp_if);
        check({tag, "_n_access"}, 32'(log_addr.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < log_addr.size(); i++) begin
            check({tag, "_addr"}, log_addr[i], ea[i]);
            check({tag, "_we"}, {31'd0, log_we[i]}, {31'd0, ewe[i]});
            if (ewe[i]) check({tag, "_wdata"}, log_wdata[i], ewd[i]);
        end
`ifdef PIPEMEM_ARB_PERF_EN
        check({tag, "_stall_cnt"}, stall_cnt, 32'(exp_total));
`else
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  kind;
        logic [31:0] a1, a2;
        mem[32'h0]  = 32'h2002_0001;
        mem[32'h40] = 32'hDEAD_BEEF;
        mem[32'h8]  = 32'h1234_5678;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_stall_idle", {31'd0, stall}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        run_slot(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "fetch0");

        do_reset();
        run_slot(1'b0, 1'b1, 32'h40, 32'h0, 1'b1, 32'h8, "ld_if");
        run_slot(1'b1, 1'b0, 32'h10, 32'hA5A5_A5A5, 1'b1, 32'h10, "st_if");
        run_slot(1'b1, 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0, 32'h0, "st_both");
        run_slot(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0, "ld_back");
        run_slot(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "no_req");

        // Reset asserted during the load's read window
        m_m2reg = 1'b1; m_wmem = 1'b0; m_addr = 32'h40; if_req = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_mem_en", {31'd0, mem_en}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_m_rdata", m_rdata, 32'd0);
        check("arst_if_rdata", if_rdata, 32'd0);
        check("arst_stall_cnt", stall_cnt, 32'd0);
        exp_total = 0; exp_m = '0; exp_if = '0;
        @(negedge clk);
        m_m2reg = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_slot(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8, "fetch_after_rst");

        for (int i = 0; i < 40; i++) begin
            kind = 4'($urandom_range(0, 15));
            a1 = 32'($urandom_range(0, 15)) << 2;
            a2 = 32'($urandom_range(0, 15)) << 2;
            run_slot(kind[0], kind[1], a1, $urandom, kind[3] | kind[2], a2, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
